// File: rtl/mem_transpose_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_transpose_pkg
//  Description : Shared types and constants for the transposing tile reader.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_transpose_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_EMIT  = 2'd3
    } mtr_state_e;

    localparam int MEM_RD_LATENCY  = 2;
    localparam int DEF_DATA_WIDTH  = 160;
    localparam int DEF_HEIGHT      = 128;
    localparam int DEF_TILE        = 16;

endpackage
`default_nettype wire

// File: rtl/mem_transpose_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_transpose_reader_if
//  Description : Request, array read port and output stream of the reader.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_transpose_reader_if #(
    parameter int DATA_WIDTH = 160,
    parameter int ADDR_LEN   = 7,
    parameter int COL_LEN    = 8,
    parameter int TILE       = 16
);
    logic                  start;
    logic [ADDR_LEN-1:0]   base_addr;
    logic [COL_LEN-1:0]    col_off;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [ADDR_LEN-1:0]   mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  out_valid;
    logic                  out_ready;
    logic [TILE-1:0]       out_data;
    logic                  out_last;

    modport master (
        output start, base_addr, col_off, mem_rdata, out_ready,
        input  busy, done, err, mem_raddr, out_valid, out_data, out_last
    );

    modport slave (
        input  start, base_addr, col_off, mem_rdata, out_ready,
        output busy, done, err, mem_raddr, out_valid, out_data, out_last
    );
endinterface
`default_nettype wire

// File: rtl/mtr_tile_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : mtr_tile_buffer
//  Description : TILE x TILE register file, row write port, column read port.
//  Revision    : 1.0  initial release
// ============================================================================
module mtr_tile_buffer #(
    parameter int TILE  = 16,
    parameter int IDX_W = $clog2(TILE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TILE-1:0]  wr_row_i,
    input  logic [IDX_W-1:0] rd_col_i,
    output logic [TILE-1:0]  rd_data_o
);
    logic [TILE-1:0] rows_q [TILE];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < TILE; r++) begin
                rows_q[r] <= '0;
            end
        end else if (wr_en_i) begin
            rows_q[wr_idx_i] <= wr_row_i;
        end
    end

    // Bit r of the column word comes from row r: this is the transpose.
    always_comb begin
        rd_data_o = '0;
        for (int r = 0; r < TILE; r++) begin
            rd_data_o[r] = rows_q[r][rd_col_i];
        end
    end
endmodule
`default_nettype wire

// File: rtl/mem_transpose_reader.sv
`default_nettype none
// ============================================================================
//  Module      : mem_transpose_reader
//  Description : Fetches a TILE x TILE bit tile from the cell array and
//                streams it out column by column. Optional macro
//                MTR_RANGE_CHECK_EN rejects tiles running past DATA_WIDTH.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_transpose_reader #(
    parameter int DATA_WIDTH = mem_transpose_pkg::DEF_DATA_WIDTH,
    parameter int HEIGHT     = mem_transpose_pkg::DEF_HEIGHT,
    parameter int ADDR_LEN   = $clog2(HEIGHT),
    parameter int TILE       = mem_transpose_pkg::DEF_TILE,
    parameter int COL_LEN    = $clog2(DATA_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_transpose_reader_if.slave bus
);
    import mem_transpose_pkg::*;

    localparam int                IDX_W     = $clog2(TILE);
    localparam int                CAP_DEPTH = MEM_RD_LATENCY + 1;
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(TILE - 1);
    localparam logic [IDX_W-1:0]  IDX_PENUL = IDX_W'(TILE - 2);
    localparam logic [ADDR_LEN-1:0] ADDR_LAST = ADDR_LEN'(HEIGHT - 1);

    mtr_state_e            state_q;
    logic                  busy_q, done_q, err_q;
    logic                  out_valid_q, out_last_q;
    logic [TILE-1:0]       out_data_q;
    logic [ADDR_LEN-1:0]   raddr_q, raddr_d;
    logic [COL_LEN-1:0]    col_q;
    logic [IDX_W-1:0]      iss_q, cap_q, beat_q;
    logic [CAP_DEPTH-1:0]  vld_q;

    logic                  w_reject, w_issue, w_capture;
    logic [TILE-1:0]       w_row, w_col_data;
    logic [IDX_W-1:0]      w_rd_col;

`ifdef MTR_RANGE_CHECK_EN
    assign w_reject = (int'(bus.col_off) > DATA_WIDTH - TILE);
`else
    assign w_reject = 1'b0;
`endif

    assign raddr_d   = (raddr_q == ADDR_LAST) ? '0 : raddr_q + ADDR_LEN'(1);
    assign w_issue   = ((state_q == ST_IDLE) && bus.start && !w_reject) ||
                       ((state_q == ST_ISSUE) && (iss_q != IDX_LAST));
    assign w_capture = vld_q[CAP_DEPTH-1];
    assign w_rd_col  = (state_q == ST_EMIT) ? beat_q + IDX_W'(1) : '0;

    // Columns beyond the array width read as zero.
    always_comb begin
        int idx;
        w_row = '0;
        idx   = 0;
        for (int k = 0; k < TILE; k++) begin
            idx = int'(col_q) + k;
            if (idx < DATA_WIDTH) begin
                w_row[k] = bus.mem_rdata[idx[COL_LEN-1:0]];
            end
        end
    end

    mtr_tile_buffer #(
        .TILE  (TILE),
        .IDX_W (IDX_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (w_capture),
        .wr_idx_i  (cap_q),
        .wr_row_i  (w_row),
        .rd_col_i  (w_rd_col),
        .rd_data_o (w_col_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            raddr_q     <= '0;
            col_q       <= '0;
            iss_q       <= '0;
            cap_q       <= '0;
            beat_q      <= '0;
            vld_q       <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            vld_q  <= {vld_q[CAP_DEPTH-2:0], w_issue};
            if (w_capture) begin
                cap_q <= (cap_q == IDX_LAST) ? '0 : cap_q + IDX_W'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (w_reject) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= ST_ISSUE;
                            busy_q  <= 1'b1;
                            raddr_q <= bus.base_addr;
                            col_q   <= bus.col_off;
                            iss_q   <= '0;
                            cap_q   <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (iss_q == IDX_LAST) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        iss_q   <= iss_q + IDX_W'(1);
                        raddr_q <= raddr_d;
                    end
                end
                ST_DRAIN: begin
                    // The last row lands in the buffer on this same edge, so
                    // its bit of column 0 is forwarded from the capture path.
                    if (w_capture && (cap_q == IDX_LAST)) begin
                        state_q     <= ST_EMIT;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        beat_q      <= '0;
                        out_data_q  <= {w_row[0], w_col_data[TILE-2:0]};
                    end
                end
                ST_EMIT: begin
                    if (bus.out_ready) begin
                        if (beat_q == IDX_LAST) begin
                            state_q     <= ST_IDLE;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            out_data_q  <= '0;
                        end else begin
                            beat_q     <= beat_q + IDX_W'(1);
                            out_data_q <= w_col_data;
                            out_last_q <= (beat_q == IDX_PENUL);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.mem_raddr = raddr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;
endmodule
`default_nettype wire
